// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive path and its bus bridge.
//   - uart_state_t      : receiver FSM state encoding (2 bits)
//   - UART_DATA_BITS    : data bits per frame
//   - UART_REG_*        : bus-bridge register offsets (DATA, STATUS)
//   - UART_STAT_*       : bit positions inside the STATUS register
//   - uart_half()       : half-bit period in clocks, rounded down
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam logic [3:0] UART_REG_DATA   = 4'h0;
  localparam logic [3:0] UART_REG_STATUS = 4'h4;

  localparam int UART_STAT_VALID     = 0;
  localparam int UART_STAT_FRAME_ERR = 1;
  localparam int UART_STAT_OVERRUN   = 2;
  localparam int UART_STAT_BUSY      = 3;

  function automatic int uart_half(input int div);
    return div / 2;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchroniser for the asynchronous serial line, followed by a
// "previous" flop used to detect a synchronised falling edge.
// All flops reset to 1 (line idle level) so reset never fakes a start edge.
// Ports:
//   i_clk   : system clock
//   i_rst   : asynchronous active-high reset
//   i_rxd   : raw serial line
//   o_level : synchronised line level
//   o_fall  : one-cycle pulse on a synchronised 1->0 transition
// -----------------------------------------------------------------------------
module uart_rx_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_rxd,
  output logic o_level,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b1;
      r_sync <= 1'b1;
      r_prev <= 1'b1;
    end else begin
      r_meta <= i_rxd;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_fall  = r_prev & ~r_sync;

endmodule

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// 8N1 UART receiver. Detects a start bit, samples 8 data bits LSB-first at
// mid-bit, checks the stop bit and holds the byte for the bus side.
// Ports:
//   clk       : system clock, rising edge
//   reset     : asynchronous active-high reset
//   rxd       : raw serial line, idle high
//   rx_ack    : one-cycle pulse, bus has read the data register
//   err_clr   : one-cycle pulse, clears frame_err and overrun
//   rx_data   : last accepted byte
//   rx_valid  : byte available, held until rx_ack
//   frame_err : sticky, stop bit sampled low
//   overrun   : sticky, byte completed while rx_valid was still high
//   busy      : receiver is inside a frame (FSM not IDLE)
//   dbg_state : current FSM state, for observation only
//
// Handshake: rx_valid is the "valid" and rx_ack the "ready/consume" of a
// one-deep output register. A byte is transferred on any clock where both are
// high; rx_ack while rx_valid is low has no effect. A new byte arriving while
// rx_valid is high is dropped (overrun) unless rx_ack is high in that same
// cycle, in which case the new byte replaces the consumed one.
// -----------------------------------------------------------------------------
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 25000000,
  parameter int BAUD     = 9600
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxd,
  input  logic        rx_ack,
  input  logic        err_clr,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        overrun,
  output logic        busy,
  output uart_state_t dbg_state
);

  // DIV must be at least 4 so that HALF >= 2 and the counters are meaningful.
  localparam int DIV  = CLK_FREQ / BAUD;
  localparam int HALF = uart_half(DIV);
  localparam int BW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW   = $clog2(UART_DATA_BITS);

  localparam logic [BW-1:0] DIV_LAST  = BW'(DIV - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(HALF - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(UART_DATA_BITS - 1);

  logic w_level;
  logic w_fall;

  uart_rx_sync u_sync (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_rxd   (rxd),
    .o_level (w_level),
    .o_fall  (w_fall)
  );

  uart_state_t               r_state;
  logic [BW-1:0]             r_baud;
  logic [IW-1:0]             r_bit_idx;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [7:0]                r_rx_data;
  logic                      r_rx_valid;
  logic                      r_frame_err;
  logic                      r_overrun;

  logic w_baud_done;
  logic w_stop_sample;
  logic w_accept;
  logic w_frame_bad;

  // START waits half a bit to land mid start-bit; every later sample is one
  // full bit apart, so it also lands mid-bit.
  assign w_baud_done   = (r_state == ST_START) ? (r_baud == HALF_LAST)
                                               : (r_baud == DIV_LAST);
  assign w_stop_sample = (r_state == ST_STOP) && w_baud_done;
  assign w_accept      = w_stop_sample &  w_level;
  assign w_frame_bad   = w_stop_sample & ~w_level;

  // Frame sequencing. The counters only restart by explicit clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state <= ST_START;
            r_baud  <= '0;
          end
        end
        ST_START: begin
          if (w_baud_done) begin
            r_baud <= '0;
            if (!w_level) begin
              r_state   <= ST_DATA;
              r_bit_idx <= '0;
            end else begin
              // Line back high at mid start-bit: a glitch, not a frame.
              r_state <= ST_IDLE;
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        ST_DATA: begin
          if (w_baud_done) begin
            r_baud             <= '0;
            r_shift[r_bit_idx] <= w_level;
            if (r_bit_idx == BIT_LAST) begin
              r_state <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + IW'(1);
            end
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        ST_STOP: begin
          // Leave at mid stop-bit so a start edge half a bit later is caught.
          if (w_baud_done) begin
            r_baud  <= '0;
            r_state <= ST_IDLE;
          end else begin
            r_baud <= r_baud + BW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Output holding register and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_accept) begin
        if (!r_rx_valid || rx_ack) begin
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end
      end else if (rx_ack) begin
        r_rx_valid <= 1'b0;
      end
      // A new error event in the same cycle as err_clr wins.
      r_frame_err <= (r_frame_err & ~err_clr) | w_frame_bad;
      r_overrun   <= (r_overrun & ~err_clr) | (w_accept & r_rx_valid & ~rx_ack);
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != ST_IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
// Directed and randomized frames against a frame-level reference model of the
// receiver's externally visible state (held byte, valid, sticky flags).
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

  localparam int CLK_FREQ  = 160;
  localparam int BAUD      = 10;
  localparam int DIV       = CLK_FREQ / BAUD;
  localparam int HALF      = DIV / 2;
  localparam int FRAME_CYC = 10 * DIV;
  // Clocks from the start edge until rx_valid is visible.
  localparam int VALID_LAT = 2 + HALF + 9 * DIV + 1;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       rxd;
  logic       rx_ack;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  uart_rx_core #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rxd       (rxd),
    .rx_ack    (rx_ack),
    .err_clr   (err_clr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];      // bytes accepted and not yet consumed
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_fe;
  logic       m_ov;
  int         lat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_data"},  32'(rx_data),   32'(m_data));
    check({tag, "_valid"}, 32'(rx_valid),  32'(m_valid));
    check({tag, "_ferr"},  32'(frame_err), 32'(m_fe));
    check({tag, "_ovr"},   32'(overrun),   32'(m_ov));
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_fe    = 1'b0;
    m_ov    = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_ack();
    if (m_valid) begin
      m_valid = 1'b0;
      void'(exp_q.pop_front());
    end
  endtask

  // Effect of one complete frame at its stop sample.
  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (!stop) begin
      m_fe = 1'b1;
    end else if (!m_valid) begin
      m_valid = 1'b1;
      m_data  = b;
      exp_q.push_back(b);
    end else begin
      m_ov = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Drives the first ncyc clocks of a frame; rx_ack pulses in cycle ack_at
  // (-1 for none). Records in lat the clock count at which rx_valid rose.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int ack_at, input int ncyc);
    logic prev_v;
    int   slot;
    prev_v = rx_valid;
    lat    = -1;
    for (int c = 0; c < ncyc; c++) begin
      slot = c / DIV;
      if (slot == 0)      rxd = 1'b0;
      else if (slot <= 8) rxd = b[slot-1];
      else                rxd = stop;
      rx_ack = (c == ack_at);
      if (c == ack_at && m_valid) check("ack_data", 32'(rx_data), 32'(exp_q[0]));
      @(negedge clk);
      if (rx_valid && !prev_v && lat < 0) lat = c + 1;
      prev_v = rx_valid;
    end
    rx_ack = 1'b0;
    if (ncyc == FRAME_CYC) begin
      if (ack_at >= 0) model_ack();
      model_frame(b, stop);
    end
  endtask

  task automatic ack_pulse();
    if (m_valid) check("ack_data", 32'(rx_data), 32'(exp_q[0]));
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    model_ack();
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_fe = 1'b0;
    m_ov = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int   busy_cnt;
    int   fe_events;
    logic prev_fe;
    logic cleared;
    logic [7:0] rb;
    logic rstop;
    int   rack;
    int   rgap;

    reset   = 1'b1;
    rxd     = 1'b1;
    rx_ack  = 1'b0;
    err_clr = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs("reset");
    check("reset_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    idle(5);
    check_outputs("post_reset");

    // Single byte, latency, then consume.
    send_frame(8'hA5, 1'b1, -1, FRAME_CYC);
    check("a5_latency", 32'(lat >= VALID_LAT - 1 && lat <= VALID_LAT + 1), 32'd1);
    check_outputs("a5");
    check("a5_busy", 32'(busy), 32'd0);
    ack_pulse();
    check_outputs("a5_acked");

    // Back-to-back, first byte consumed before the second completes.
    send_frame(8'h3C, 1'b1, -1, FRAME_CYC);
    send_frame(8'hC3, 1'b1, 20, FRAME_CYC);
    check_outputs("b2b_ack");
    ack_pulse();
    // Back-to-back without consuming: second byte dropped.
    send_frame(8'h3C, 1'b1, -1, FRAME_CYC);
    send_frame(8'hC3, 1'b1, -1, FRAME_CYC);
    check_outputs("b2b_ovr");
    clear_errors();
    check_outputs("ovr_clr");
    ack_pulse();

    // Short low glitch.
    busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      rxd = (c < 5) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (busy) busy_cnt++;
    end
    check("glitch_seen_busy", 32'(busy_cnt > 0), 32'd1);
    check_outputs("glitch");
    check("glitch_busy", 32'(busy), 32'd0);

    // Bad stop bit, then line stays low: no new frame may start.
    send_frame(8'h55, 1'b0, -1, FRAME_CYC);
    check_outputs("ferr");
    clear_errors();
    busy_cnt = 0;
    fe_events = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (frame_err) fe_events++;
    end
    check("low_hold_busy", 32'(busy_cnt), 32'd0);
    check("low_hold_ferr", 32'(fe_events), 32'd0);

    // Break from idle: exactly one 0x00 frame with frame error.
    idle(20);
    rxd = 1'b0;
    fe_events = 0;
    prev_fe = frame_err;
    cleared = 1'b0;
    busy_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      err_clr = 1'b0;
      if (fe_events == 1 && !cleared) begin
        err_clr = 1'b1;
        cleared = 1'b1;
      end
      @(negedge clk);
      if (frame_err && !prev_fe) fe_events++;
      prev_fe = frame_err;
      if (fe_events > 0 && busy) busy_cnt++;
    end
    err_clr = 1'b0;
    model_frame(8'h00, 1'b0);
    m_fe = 1'b0;
    check("break_events", 32'(fe_events), 32'd1);
    check("break_busy_after", 32'(busy_cnt), 32'd0);
    check_outputs("break");
    idle(20);
    send_frame(8'h01, 1'b1, -1, FRAME_CYC);
    check_outputs("after_break");
    ack_pulse();

    // Reset in the middle of data bit 4.
    send_frame(8'hFF, 1'b1, -1, 5 * DIV + HALF);
    check("mid_frame_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_reset");
    check("async_reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    check_outputs("reset_held");
    reset = 1'b0;
    idle(10);
    send_frame(8'h12, 1'b1, -1, FRAME_CYC);
    check("x12_latency", 32'(lat >= VALID_LAT - 1 && lat <= VALID_LAT + 1), 32'd1);
    check_outputs("x12");
    ack_pulse();

    // Consume coincident with the stop sample of the next byte.
    send_frame(8'h77, 1'b1, -1, FRAME_CYC);
    check_outputs("x77");
    send_frame(8'h88, 1'b1, VALID_LAT - 1, FRAME_CYC);
    check_outputs("coincident");
    ack_pulse();

    // Randomized frames.
    for (int i = 0; i < 12; i++) begin
      rb    = 8'($urandom_range(0, 255));
      rstop = ($urandom_range(0, 4) != 0);
      rack  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, VALID_LAT - 1)) : -1;
      send_frame(rb, rstop, rack, FRAME_CYC);
      check_outputs("rand");
      if ($urandom_range(0, 3) == 0) begin
        clear_errors();
        check_outputs("rand_clr");
      end
      rgap = rstop ? int'($urandom_range(0, 20)) : int'($urandom_range(DIV, 2 * DIV));
      idle(rgap);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
